// File: rtl/mem_controller_if.sv
// CPU-side request/response bus and RAM pin bundle for mem_controller.
// The slave view is the controller; the master view is everything around it.
interface mem_controller_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned LEN_W  = 2
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [LEN_W-1:0]  cpu_len;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_busy;
    logic              cpu_wnext;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_rlast;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic [ADDR_W-1:0] mc_address_mem;
    logic              mem_we;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_len, cpu_wdata, mem_data_out,
        output cpu_ack, cpu_busy, cpu_wnext, cpu_rdata, cpu_rvalid, cpu_rlast,
        output mem_data_in, mc_address_mem, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_len, cpu_wdata, mem_data_out,
        input  cpu_ack, cpu_busy, cpu_wnext, cpu_rdata, cpu_rvalid, cpu_rlast,
        input  mem_data_in, mc_address_mem, mem_we
    );
endinterface

// File: rtl/mem_controller.sv
// Single-master controller for a 64x32 single-port RAM with a registered read address.
// Serves 1..4 beat read/write bursts; every output is driven straight from a flop.
module mem_controller #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned LEN_W  = 2
) (
    input logic              mem_clk,
    input logic              mem_rst,
    mem_controller_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              ack_q;
    logic              busy_q;
    logic              wnext_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              rlast_q;
    // Read beat tracking: iss = address on the RAM pins, cap = address held inside the RAM.
    logic              iss_v_q;
    logic              iss_last_q;
    logic              cap_v_q;
    logic              cap_last_q;

    logic [LEN_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    assign cnt_nxt  = cnt_q + LEN_W'(1);
    assign addr_nxt = addr_q + ADDR_W'(1);

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            wnext_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            iss_v_q    <= 1'b0;
            iss_last_q <= 1'b0;
            cap_v_q    <= 1'b0;
            cap_last_q <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            wnext_q    <= 1'b0;
            iss_v_q    <= 1'b0;
            iss_last_q <= 1'b0;
            cap_v_q    <= iss_v_q;
            cap_last_q <= iss_last_q;
            rvalid_q   <= cap_v_q;
            rlast_q    <= cap_v_q & cap_last_q;
            if (cap_v_q) begin
                rdata_q <= bus.mem_data_out;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.cpu_req) begin
                        ack_q  <= 1'b1;
                        busy_q <= 1'b1;
                        len_q  <= bus.cpu_len;
                        cnt_q  <= '0;
                        addr_q <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            we_q    <= 1'b1;
                            wdata_q <= bus.cpu_wdata;
                            wnext_q <= (bus.cpu_len != '0);
                            state_q <= StWrite;
                        end else begin
                            iss_v_q    <= 1'b1;
                            iss_last_q <= (bus.cpu_len == '0);
                            state_q    <= (bus.cpu_len == '0) ? StDrain : StRead;
                        end
                    end
                end
                StWrite: begin
                    if (cnt_q == len_q) begin
                        // Last beat is committed by the RAM at this edge.
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= cnt_nxt;
                        addr_q  <= addr_nxt;
                        wdata_q <= bus.cpu_wdata;
                        wnext_q <= (cnt_nxt != len_q);
                    end
                end
                StRead: begin
                    cnt_q      <= cnt_nxt;
                    addr_q     <= addr_nxt;
                    iss_v_q    <= 1'b1;
                    iss_last_q <= (cnt_nxt == len_q);
                    if (cnt_nxt == len_q) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave once the final beat is being registered onto cpu_rdata.
                    if (cap_v_q && cap_last_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cpu_ack        = ack_q;
    assign bus.cpu_busy       = busy_q;
    assign bus.cpu_wnext      = wnext_q;
    assign bus.cpu_rdata      = rdata_q;
    assign bus.cpu_rvalid     = rvalid_q;
    assign bus.cpu_rlast      = rlast_q;
    assign bus.mem_data_in    = wdata_q;
    assign bus.mc_address_mem = addr_q;
    assign bus.mem_we         = we_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: behavioural 64x32 RAM with registered read address,
// a table of burst transactions plus hand-written reset sequences.
module tb_mem_controller;

    logic clk;
    logic rst;

    mem_controller_if #(.DATA_W(32), .ADDR_W(6), .LEN_W(2)) bus ();

    mem_controller #(.DATA_W(32), .ADDR_W(6), .LEN_W(2)) dut (
        .mem_clk (clk),
        .mem_rst (rst),
        .bus     (bus)
    );

    logic [31:0] ram [64];
    logic [5:0]  raddr_q;

    always_ff @(posedge clk) begin
        if (bus.mem_we) ram[bus.mc_address_mem] <= bus.mem_data_in;
        raddr_q <= bus.mc_address_mem;
    end
    assign bus.mem_data_out = ram[raddr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic             we;
        logic [5:0]       addr;
        logic [1:0]       len;
        logic             busy_req;
        logic [3:0][31:0] d;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(input logic we, input logic [5:0] addr, input logic [1:0] len,
                                input logic busy_req, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3);
        vec_t v;
        v.we       = we;
        v.addr     = addr;
        v.len      = len;
        v.busy_req = busy_req;
        v.d[0]     = d0;
        v.d[1]     = d1;
        v.d[2]     = d2;
        v.d[3]     = d3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " ack"},    32'(bus.cpu_ack), 32'd0);
        chk({tag, " busy"},   32'(bus.cpu_busy), 32'd0);
        chk({tag, " wnext"},  32'(bus.cpu_wnext), 32'd0);
        chk({tag, " rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
        chk({tag, " rlast"},  32'(bus.cpu_rlast), 32'd0);
        chk({tag, " rdata"},  bus.cpu_rdata, 32'd0);
        chk({tag, " we"},     32'(bus.mem_we), 32'd0);
        chk({tag, " addr"},   32'(bus.mc_address_mem), 32'd0);
        chk({tag, " wdata"},  bus.mem_data_in, 32'd0);
    endtask

    // Presents the request for edge E0; each loop pass observes the cycle after E(c-1).
    task automatic run_vec(input int idx, input vec_t v);
        int          len;
        logic [5:0]  ea;
        string       t;
        len = int'(v.len);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_addr  = v.addr;
        bus.cpu_len   = v.len;
        bus.cpu_wdata = v.we ? v.d[0] : 32'h0;
        if (v.we) begin
            for (int c = 1; c <= len + 2; c++) begin
                @(negedge clk);
                t = $sformatf("v%0d wr c%0d", idx, c);
                chk({t, " ack"},    32'(bus.cpu_ack), 32'(c == 1));
                chk({t, " busy"},   32'(bus.cpu_busy), 32'(c <= len + 1));
                chk({t, " we"},     32'(bus.mem_we), 32'(c <= len + 1));
                chk({t, " wnext"},  32'(bus.cpu_wnext), 32'(c <= len));
                chk({t, " rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
                if (c <= len + 1) begin
                    ea = v.addr + 6'(c - 1);
                    chk({t, " addr"},  32'(bus.mc_address_mem), 32'(ea));
                    chk({t, " wdata"}, bus.mem_data_in, v.d[c-1]);
                end
                bus.cpu_req   = 1'b0;
                bus.cpu_wdata = (c <= len) ? v.d[c] : 32'h0;
            end
            for (int k = 0; k <= len; k++) begin
                ea = v.addr + 6'(k);
                chk($sformatf("v%0d ram[%0d]", idx, ea), ram[ea], v.d[k]);
            end
        end else begin
            for (int c = 1; c <= len + 4; c++) begin
                @(negedge clk);
                t = $sformatf("v%0d rd c%0d", idx, c);
                chk({t, " ack"},    32'(bus.cpu_ack), 32'(c == 1));
                chk({t, " busy"},   32'(bus.cpu_busy), 32'(c <= len + 2));
                chk({t, " rvalid"}, 32'(bus.cpu_rvalid), 32'(c >= 3 && c <= len + 3));
                chk({t, " rlast"},  32'(bus.cpu_rlast), 32'(c == len + 3));
                chk({t, " we"},     32'(bus.mem_we), 32'd0);
                chk({t, " wnext"},  32'(bus.cpu_wnext), 32'd0);
                if (c <= len + 1) begin
                    ea = v.addr + 6'(c - 1);
                    chk({t, " addr"}, 32'(bus.mc_address_mem), 32'(ea));
                end
                if (c >= 3 && c <= len + 3) begin
                    chk({t, " rdata"}, bus.cpu_rdata, v.d[c-3]);
                end
                // Optionally keep requesting while busy; it must be ignored.
                bus.cpu_req = v.busy_req && (c <= len + 1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1'b1, 6'd5,  2'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        tbl[1] = mk(1'b0, 6'd5,  2'd0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        tbl[2] = mk(1'b1, 6'd62, 2'd3, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        tbl[3] = mk(1'b0, 6'd62, 2'd3, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44);
        tbl[4] = mk(1'b1, 6'd20, 2'd1, 1'b0, 32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0);
        tbl[5] = mk(1'b0, 6'd20, 2'd1, 1'b1, 32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0);
        tbl[6] = mk(1'b0, 6'd63, 2'd1, 1'b0, 32'h22, 32'h33, 32'h0, 32'h0);
        tbl[7] = mk(1'b1, 6'd12, 2'd3, 1'b0, 32'h55555555, 32'h66666666, 32'h77777777,
                    32'h88888888);
        tbl[8] = mk(1'b0, 6'd4,  2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);

        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_len   = '0;
        bus.cpu_wdata = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Locations 4 and 6 are seeded so vector 8 reads known data.
        run_vec(100, mk(1'b1, 6'd4, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
        for (int i = 0; i < 9; i++) begin
            run_vec(i, tbl[i]);
        end

        // Reset during beat 2 of a 4-beat write to 12..15.
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 6'd12;
        bus.cpu_len   = 2'd3;
        bus.cpu_wdata = 32'hA0A0A0A0;
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_wdata = 32'hA1A1A1A1;
        @(negedge clk);
        bus.cpu_wdata = 32'hA2A2A2A2;
        @(negedge clk);
        chk("rstw pre we",   32'(bus.mem_we), 32'd1);
        chk("rstw pre addr", 32'(bus.mc_address_mem), 32'd14);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rstw async");
        @(negedge clk);
        @(negedge clk);
        chk_idle_outputs("rstw held");
        rst = 1'b0;
        chk("rstw ram[12]", ram[12], 32'hA0A0A0A0);
        chk("rstw ram[13]", ram[13], 32'hA1A1A1A1);
        chk("rstw ram[14]", ram[14], 32'h77777777);
        chk("rstw ram[15]", ram[15], 32'h88888888);
        run_vec(200, mk(1'b0, 6'd12, 2'd3, 1'b0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'h77777777,
                        32'h88888888));

        // Reset during a read burst: no beat may surface afterwards.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 6'd62;
        bus.cpu_len  = 2'd3;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstr busy",   32'(bus.cpu_busy), 32'd0);
        chk("rstr rvalid", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rstr after c%0d rvalid", c), 32'(bus.cpu_rvalid), 32'd0);
            chk($sformatf("rstr after c%0d busy", c),   32'(bus.cpu_busy), 32'd0);
        end
        run_vec(300, mk(1'b1, 6'd63, 2'd0, 1'b0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0));
        run_vec(301, mk(1'b0, 6'd62, 2'd2, 1'b0, 32'h11, 32'h0BADF00D, 32'h33, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Memory controller that sits directly upstream of the 64x32 single-port RAM and is its only master.
- Accepts single or short-burst read/write requests from a CPU-side requester.
- Drives the RAM's write-enable, address and write-data pins, and returns read data with valid/last flags.
- Accounts for the RAM's registered read address: read data becomes visible one cycle after the address is captured.

Parameters:
- DATA_W, 32, data width of the CPU and RAM data paths
- ADDR_W, 6, word address width (64 words)
- LEN_W, 2, burst length field width; beats = cpu_len+1 (1..4)

Ports:
- mem_clk  in  1  single clock for the controller and the RAM
- mem_rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = write burst, 0 = read burst
- cpu_addr  in  ADDR_W  start word address
- cpu_len  in  LEN_W  beats minus one
- cpu_wdata  in  DATA_W  write data: beat 0 is sampled with the request, beat k while cpu_wnext=1
- cpu_ack  out  1  one-cycle pulse: request accepted
- cpu_busy  out  1  controller not in IDLE
- cpu_wnext  out  1  cpu_wdata is sampled at the coming edge as the next write beat
- cpu_rdata  out  DATA_W  read beat data
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_rlast  out  1  marks the final read beat
- mem_data_out  in  DATA_W  RAM read data
- mem_data_in  out  DATA_W  RAM write data
- mc_address_mem  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable

Behaviour:
- All outputs are registered.
- Asynchronous reset clears every output to 0 and sets state=IDLE, beat counter=0, read pipeline=empty.
- Reset mid-burst abandons the burst immediately: mem_we drops at reset assertion. Beats already written stay in the RAM; no further cpu_rvalid is produced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cpu_busy=0.
  - On an edge E0 with cpu_req=1: cpu_ack=1 for the following cycle, busy=1, latch we/len, mc_address_mem<=cpu_addr.
  - Requests seen outside IDLE are ignored, not queued.
- WRITE path:
  - At E0: mem_we<=1, mem_data_in<=cpu_wdata (beat 0).
  - For each further beat k (1..len) at edge Ek: mc_address_mem<=addr+k, mem_data_in<=cpu_wdata.
  - cpu_wnext=1 during the cycle ending at Ek, for k=1..len; it is never high for len=0.
  - The RAM commits beat k at edge E(k+1).
  - At E(len+1): mem_we<=0, state IDLE, busy<=0.
- READ path:
  - Address issue: the address for beat k is issued at Ek (mem_we=0), and the RAM captures it at E(k+1).
  - Data capture: at E(k+2) the controller registers cpu_rdata<=mem_data_out and cpu_rvalid<=1.
  - Beats stream back-to-back: rvalid for beat k is high in the cycle after E(k+2).
  - cpu_rlast accompanies beat len.
  - After the last address is issued (E(len)): state DRAIN. At E(len+2), which captures the last beat: state IDLE, busy<=0.
  - First-beat latency: 3 edges from request sample to rvalid-high cycle.
- Address arithmetic is modulo 2^ADDR_W: 63+1 wraps to 0.
- mem_we is never high in READ or DRAIN. mem_we and cpu_rvalid are never high together for the same burst.
- cpu_ack, cpu_wnext, cpu_rvalid and cpu_rlast are 0 whenever not explicitly asserted above.

Test Plan:
- Single write: req, we=1, addr=5, len=0, wdata=0xDEADBEEF -> ack pulse, mem_we high exactly 1 cycle with addr 5; RAM[5]=0xDEADBEEF; busy low after 1 cycle.
- Single read: read addr=5, len=0 after the write -> rvalid+rlast high in the 3rd cycle after the request edge, rdata=0xDEADBEEF, rvalid high for 1 cycle.
- Write burst with wrap: addr=62, len=3, data 0x11,0x22,0x33,0x44 -> wnext high for 3 cycles; RAM[62,63,0,1]=0x11,0x22,0x33,0x44.
- Read burst with wrap: addr=62, len=3 -> 4 consecutive rvalid cycles with 0x11,0x22,0x33,0x44; rlast only on 0x44.
- Request while busy: assert cpu_req during a read burst -> ignored (no ack, no extra beats); next req accepted only after busy falls.
- Reset mid-burst: assert mem_rst during beat 2 of a 4-beat write -> all outputs 0 immediately; RAM holds beats 0-1 only; the next request behaves normally.
